ad7606_conv_seq: RTL

- Conversion sequencer for the AD7606 parallel interface.
- Issues the AD7606 RESET pulse after power-up, then triggers CONVST at a programmable sample period and waits for BUSY.
- Reads NUM_CH channels through CS/RD and streams the 16-bit results with a valid strobe.
- Sits between the board-level ADC pins and the sample-processing datapath. It runs alongside the block that writes the AD7606 range/oversampling configuration.

---
 rtl/ad7606_conv_seq.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/ad7606_conv_seq.sv
// AD7606 parallel-interface conversion sequencer: RESET, periodic CONVST, BUSY wait, CS/RD readout.
// Optional frame counter on frame_cnt_o when AD7606_SEQ_FRAME_CNT_EN is defined.
module ad7606_conv_seq #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned RST_CYC    = 8,
  parameter int unsigned T_CONV_LOW = 4,
  parameter int unsigned T_RD_LOW   = 3,
  parameter int unsigned T_RD_HIGH  = 2,
  parameter int unsigned BUSY_TMO   = 1024
) (
  input  logic        led_clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [15:0] period_i,
  input  logic        busy_i,
  input  logic [15:0] db_i,
  output logic        adc_reset_o,
  output logic        convst_n_o,
  output logic        cs_n_o,
  output logic        rd_n_o,
  output logic [15:0] sample_o,
  output logic [2:0]  sample_ch_o,
  output logic        sample_valid_o,
  output logic        frame_done_o,
  output logic        overrun_o,
  output logic        timeout_o,
  output logic [15:0] frame_cnt_o
);

  localparam int unsigned M_A     = (RST_CYC > T_CONV_LOW) ? RST_CYC : T_CONV_LOW;
  localparam int unsigned M_B     = (T_RD_LOW > T_RD_HIGH) ? T_RD_LOW : T_RD_HIGH;
  localparam int unsigned M_C     = (M_A > M_B) ? M_A : M_B;
  localparam int unsigned TMR_MAX = (M_C > BUSY_TMO) ? M_C : BUSY_TMO;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    S_RST_ADC, S_IDLE, S_CONV, S_WAIT_HI, S_WAIT_LO, S_RD_L, S_RD_H
  } state_t;

  state_t             state, state_d;
  logic [TMR_W-1:0]   tmr, tmr_d;
  logic [2:0]         ch, ch_d;
  logic               adc_reset_d, convst_d, cs_d, rd_d;
  logic [15:0]        sample_d;
  logic [2:0]         sample_ch_d;
  logic               valid_d, done_d, overrun_d, timeout_d;

  logic [15:0]        per_q, per_cnt, per_last;
  logic               start_tick;
  logic               busy_m, busy_s;

  // Period generator: period_i is latched while disabled and at every reload
  assign per_last = (per_q == 16'd0) ? 16'd0 : per_q - 16'd1;

  always_ff @(posedge led_clk_i) begin
    if (rst_i) begin
      per_q      <= 16'd0;
      per_cnt    <= 16'd0;
      start_tick <= 1'b0;
    end else if (!enable_i) begin
      per_q      <= period_i;
      per_cnt    <= 16'd0;
      start_tick <= 1'b0;
    end else if (per_cnt == per_last) begin
      per_q      <= period_i;
      per_cnt    <= 16'd0;
      start_tick <= 1'b1;
    end else begin
      per_cnt    <= per_cnt + 16'd1;
      start_tick <= 1'b0;
    end
  end

  always_ff @(posedge led_clk_i) begin
    if (rst_i) begin
      busy_m <= 1'b0;
      busy_s <= 1'b0;
    end else begin
      busy_m <= busy_i;
      busy_s <= busy_m;
    end
  end

  // State and registered outputs
  always_ff @(posedge led_clk_i) begin
    if (rst_i) begin
      state          <= S_RST_ADC;
      tmr            <= '0;
      ch             <= 3'd0;
      adc_reset_o    <= 1'b1;
      convst_n_o     <= 1'b1;
      cs_n_o         <= 1'b1;
      rd_n_o         <= 1'b1;
      sample_o       <= 16'd0;
      sample_ch_o    <= 3'd0;
      sample_valid_o <= 1'b0;
      frame_done_o   <= 1'b0;
      overrun_o      <= 1'b0;
      timeout_o      <= 1'b0;
    end else begin
      state          <= state_d;
      tmr            <= tmr_d;
      ch             <= ch_d;
      adc_reset_o    <= adc_reset_d;
      convst_n_o     <= convst_d;
      cs_n_o         <= cs_d;
      rd_n_o         <= rd_d;
      sample_o       <= sample_d;
      sample_ch_o    <= sample_ch_d;
      sample_valid_o <= valid_d;
      frame_done_o   <= done_d;
      overrun_o      <= overrun_d;
      timeout_o      <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state;
    tmr_d       = tmr;
    ch_d        = ch;
    adc_reset_d = adc_reset_o;
    convst_d    = convst_n_o;
    cs_d        = cs_n_o;
    rd_d        = rd_n_o;
    sample_d    = sample_o;
    sample_ch_d = sample_ch_o;
    valid_d     = 1'b0;
    done_d      = 1'b0;
    overrun_d   = overrun_o | (start_tick && (state != S_IDLE));
    timeout_d   = timeout_o;

    case (state)
      S_RST_ADC: begin
        adc_reset_d = 1'b1;
        if (tmr == TMR_W'(RST_CYC - 1)) begin
          adc_reset_d = 1'b0;
          tmr_d       = '0;
          state_d     = S_IDLE;
        end else begin
          tmr_d = tmr + 1'b1;
        end
      end
      S_IDLE: begin
        if (start_tick) begin
          convst_d = 1'b0;
          tmr_d    = '0;
          state_d  = S_CONV;
        end
      end
      S_CONV: begin
        if (tmr == TMR_W'(T_CONV_LOW - 1)) begin
          convst_d = 1'b1;
          tmr_d    = '0;
          state_d  = S_WAIT_HI;
        end else begin
          tmr_d = tmr + 1'b1;
        end
      end
      S_WAIT_HI: begin
        if (busy_s) begin
          tmr_d   = '0;
          state_d = S_WAIT_LO;
        end else if (tmr == TMR_W'(BUSY_TMO - 1)) begin
          timeout_d = 1'b1;
          tmr_d     = '0;
          state_d   = S_IDLE;
        end else begin
          tmr_d = tmr + 1'b1;
        end
      end
      S_WAIT_LO: begin
        if (!busy_s) begin
          ch_d    = 3'd0;
          cs_d    = 1'b0;
          rd_d    = 1'b0;
          tmr_d   = '0;
          state_d = S_RD_L;
        end else if (tmr == TMR_W'(BUSY_TMO - 1)) begin
          timeout_d = 1'b1;
          tmr_d     = '0;
          state_d   = S_IDLE;
        end else begin
          tmr_d = tmr + 1'b1;
        end
      end
      // Capture on the last low clock so the valid strobe lines up with the RD rising edge
      S_RD_L: begin
        if (tmr == TMR_W'(T_RD_LOW - 1)) begin
          sample_d    = db_i;
          sample_ch_d = ch;
          valid_d     = 1'b1;
          rd_d        = 1'b1;
          tmr_d       = '0;
          state_d     = S_RD_H;
        end else begin
          tmr_d = tmr + 1'b1;
        end
      end
      S_RD_H: begin
        if (tmr == TMR_W'(T_RD_HIGH - 1)) begin
          tmr_d = '0;
          if (ch < 3'(NUM_CH - 1)) begin
            ch_d    = ch + 1'b1;
            rd_d    = 1'b0;
            state_d = S_RD_L;
          end else begin
            cs_d    = 1'b1;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          tmr_d = tmr + 1'b1;
        end
      end
      default: state_d = S_RST_ADC;
    endcase
  end

`ifdef AD7606_SEQ_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge led_clk_i) begin
    if (rst_i) begin
      frame_cnt_q <= 16'd0;
    end else if (done_d) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
`else
  assign frame_cnt_o = 16'd0;
`endif

endmodule
